// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. A single full-adder cell (two half-adder
// stages plus a carry flip-flop) is stepped across WIDTH-bit operands,
// LSB first, one bit per clock. Requesters use a start/busy/done handshake.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, a 'sub' input appears. With sub=1 the B bits are inverted
//   into the cell and the carry starts at 1, so the result is a-b in two's
//   complement and carry_out=1 means "no borrow" (a >= b unsigned).
//   When undefined the block is a plain adder and has no 'sub' port.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      request; only sampled in IDLE
//   a          in   WIDTH  operand A, latched on accepted start
//   b          in   WIDTH  operand B, latched on accepted start
//   sub        in   1      (SERIAL_ADD_SUB_EN only) subtract select, latched
//   busy       out  1      high while the serial add is running
//   done       out  1      one-cycle pulse, sum/carry_out valid
//   sum        out  WIDTH  result register, holds until next op completes
//   carry_out  out  1      final carry out of the MSB
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_reg;
`endif

    logic b_bit;
    logic half_sum;
    logic half_carry;
    logic bit_sum;
    logic bit_carry;

    // The shared full-adder cell, built from two half adders. Operand
    // registers shift right so bit 0 is always the bit being processed.
    // In subtract mode B is inverted on its way into the cell.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_bit = b_reg[0] ^ sub_reg;
`else
        b_bit = b_reg[0];
`endif
        half_sum   = a_reg[0] ^ b_bit;
        half_carry = a_reg[0] & b_bit;
        bit_sum    = half_sum ^ carry_reg;
        bit_carry  = half_carry | (carry_reg & half_sum);
    end

    // Control FSM and datapath registers. Result bits enter at the MSB of
    // res_reg and move down, so after WIDTH steps the LSB-first stream sits
    // in natural order. sum/carry_out are only written on the final step,
    // which keeps the previous result visible through IDLE and RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_ADD_SUB_EN
                        sub_reg   <= sub;
                        carry_reg <= sub;
`else
                        carry_reg <= 1'b0;
`endif
                    end
                end

                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= bit_carry;
                    res_reg   <= {bit_sum, res_reg[WIDTH-1:1]};
                    if (cnt == LAST_BIT) begin
                        sum       <= {bit_sum, res_reg[WIDTH-1:1]};
                        carry_out <= bit_carry;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
// from plain integer arithmetic on the operands; timing expectations come
// from the handshake rules (WIDTH busy cycles, then a single done cycle).
// Define SERIAL_ADD_SUB_EN on both files to exercise subtract mode.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [W-1:0] lastSum   = '0;
    logic         lastCarry = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1 unit later.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Reference model: unsigned sum/difference with the carry as bit W.
    function automatic logic [W:0] modelResult(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
        int unsigned r;
        if (s) begin
            r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
            return {(x >= y), r[W-1:0]};
        end
        r = int'(x) + int'(y);
        return r[W:0];
    endfunction

    // One complete operation with full handshake timing checks. If noisy,
    // start is held high with garbage operands during RUN and DONE, which
    // must not affect the result nor trigger a second operation.
    task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic si, input bit noisy);
        logic [W:0] exp;
        exp   = modelResult(ai, bi, si);
        a     = ai;
        b     = bi;
        start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub   = si;
`endif
        stepCycle();
        start = noisy;
        if (noisy) begin
            a = '1;
            b = '1;
`ifdef SERIAL_ADD_SUB_EN
            sub = ~si;
`endif
        end
        for (int k = 0; k < W; k++) begin
            checkOutput("busy_run", busy, 1);
            checkOutput("done_run", done, 0);
            checkOutput("sum_hold_run", sum, lastSum);
            checkOutput("carry_hold_run", carry_out, lastCarry);
            stepCycle();
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("sum", sum, exp[W-1:0]);
        checkOutput("carry_out", carry_out, exp[W]);
        lastSum   = exp[W-1:0];
        lastCarry = exp[W];
        stepCycle();
        checkOutput("done_cleared", done, 0);
        checkOutput("busy_idle", busy, 0);
        start = 1'b0;
        if (noisy) begin
            stepCycle();
            checkOutput("no_requeue", busy, 0);
            checkOutput("sum_after_noise", sum, lastSum);
        end
    endtask

    // Reset while the serial add is mid-way; outputs clear immediately
    // and the aborted op never produces a done pulse.
    task automatic resetMidRun();
        a     = 8'hA5;
        b     = 8'h3C;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int k = 0; k < 4; k++) stepCycle();
        checkOutput("busy_before_rst", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_carry", carry_out, 0);
        lastSum   = '0;
        lastCarry = 1'b0;
        #1;
        rst = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            stepCycle();
            checkOutput("no_done_after_rst", done, 0);
            checkOutput("idle_after_rst", busy, 0);
        end
    endtask

    // start held high for three ops: acceptances every W+2 cycles, single
    // cycle done pulses, sum stable between them.
    task automatic backToBack();
        logic [W-1:0] opA [3];
        logic [W-1:0] opB [3];
        logic [W:0]   exp;
        int accCount  = 0;
        int doneCount = 0;
        int lastAcc   = 0;
        logic prevBusy = 1'b0;
        logic prevDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opA[i] = W'($urandom);
            opB[i] = W'($urandom);
        end
        a     = opA[0];
        b     = opB[0];
        start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        for (int c = 0; c < 36; c++) begin
            stepCycle();
            if (busy && !prevBusy) begin
                if (accCount > 0) checkOutput("accept_spacing", cycle - lastAcc, W + 2);
                lastAcc = cycle;
                accCount++;
                if (accCount < 3) begin
                    a = opA[accCount];
                    b = opB[accCount];
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                checkOutput("done_single", prevDone, 0);
                if (doneCount < 3) begin
                    exp = modelResult(opA[doneCount], opB[doneCount], 1'b0);
                    checkOutput("b2b_sum", sum, exp[W-1:0]);
                    checkOutput("b2b_carry", carry_out, exp[W]);
                    lastSum   = exp[W-1:0];
                    lastCarry = exp[W];
                end
                doneCount++;
            end else begin
                checkOutput("b2b_sum_stable", sum, lastSum);
            end
            prevBusy = busy;
            prevDone = done;
        end
        checkOutput("b2b_accepts", accCount, 3);
        checkOutput("b2b_dones", doneCount, 3);
        start = 1'b0;
    endtask

    // Main sequence: reset, directed scenarios, then random operations.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_carry", carry_out, 0);
        @(negedge clk);
        rst = 1'b0;
        stepCycle();

        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h11, 8'h22, 1'b0, 1'b1);

        resetMidRun();
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);

        backToBack();
        stepCycle();
        stepCycle();

`ifdef SERIAL_ADD_SUB_EN
        applyStimulus(8'h10, 8'h01, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h5A, 8'h5A, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
            applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'($urandom));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
